// File: rtl/sniff_fifo_buf.sv
// Sniffer-data FIFO: 18-bit single-clock buffer with held read port and sticky flags.
// Define SNIFF_FIFO_OVF_MARKER_EN to insert an 18'h3FFFF marker after an overflow gap.
module sniff_fifo_buf #(
  parameter int pDEPTH_LOG2  = 10,
  parameter int pALMOST_FULL = 1000
) (
  input  logic                   cwusb_clk,
  input  logic                   reset_i,
  input  logic [17:0]            I_data,
  input  logic                   I_wr,
  input  logic                   I_fifo_read,
  input  logic                   I_clear_flags,
  output logic [17:0]            O_fifo_data,
  output logic [5:0]             O_fifo_status,
  output logic                   O_fifo_empty,
  output logic                   O_full,
  output logic [pDEPTH_LOG2:0]   O_count
);

  localparam int AW = pDEPTH_LOG2;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** AW);
  localparam logic [CW-1:0] AFULL = CW'(pALMOST_FULL);

  logic [17:0]   mem [2**AW];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [17:0]   data_q;
  logic          ovf;
  logic          unf;
  logic          mp;

  logic          empty;
  logic          full;
  logic          afull;
  logic          rd_ok;
  logic          space;
  logic          drop;
  logic          wr_ok;
  logic [17:0]   wdata;
  logic          mp_next;

  always_comb begin
    empty = (count == '0);
    full  = (count == DEPTH);
    afull = (count >= AFULL);
    rd_ok = I_fifo_read && !empty;
    // a read in the same cycle frees the slot a full-FIFO write needs
    space = !full || rd_ok;
    drop  = I_wr && !space;
`ifdef SNIFF_FIFO_OVF_MARKER_EN
    wr_ok   = space && (mp || I_wr);
    wdata   = mp ? 18'h3FFFF : I_data;
    mp_next = mp ? !space : drop;
`else
    wr_ok   = I_wr && space;
    wdata   = I_data;
    mp_next = 1'b0;
`endif
  end

  always_ff @(posedge cwusb_clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge cwusb_clk) begin
    if (reset_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      data_q <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      mp     <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
        data_q <= mem[rd_ptr];
      end
      count <= count + CW'(wr_ok) - CW'(rd_ok);
      ovf   <= (ovf && !I_clear_flags) || drop;
      unf   <= (unf && !I_clear_flags) || (I_fifo_read && empty);
      mp    <= mp_next;
    end
  end

  assign O_fifo_data   = data_q;
  assign O_fifo_status = {mp, unf, ovf, afull, full, empty};
  assign O_fifo_empty  = empty;
  assign O_full        = full;
  assign O_count       = count;

endmodule
